// File: rtl/shadd_pkg.sv
// -----------------------------------------------------------------------------
// shadd_pkg
//
// Shared definitions for the shared segmented-adder scheduler (shadd_sched)
// and its datapath (shadd_seg_datapath):
//   - state_e      : scheduler states IDLE / RUN / DONE
//   - id_width()   : requester-id width, max(1, clog2(R))
//   - seg_count()  : number of N-bit segments in a W-bit add, S = W/N
//   - params_ok()  : W must be a non-zero multiple of N; the top raises an
//                    elaboration error when this does not hold
// -----------------------------------------------------------------------------
package shadd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int id_width(input int r);
        return (r <= 1) ? 1 : $clog2(r);
    endfunction

    function automatic int seg_count(input int w, input int n);
        return w / n;
    endfunction

    function automatic bit params_ok(input int w, input int n);
        return (n > 0) && (w >= n) && ((w % n) == 0);
    endfunction

endpackage

// File: rtl/shadd_seg_datapath.sv
// -----------------------------------------------------------------------------
// shadd_seg_datapath
//
// W-bit adder split into S = W/N segments of N bits. Each segment's carry-in
// comes from a register holding the previous segment's carry-out, so a carry
// travels one segment per clock and the sum is final S-1 edges after load.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_       in   asynchronous active-low reset (clears the carry registers)
//   load_i     in   capture a_i/b_i and synchronously clear all carry registers
//   adv_i      in   advance the carry registers by one segment
//   a_i, b_i   in   W-bit operands
//   sum_o      out  combinational sum of the current operand/carry state
//   seg_cout_o out  per-segment carry-out, bit S-1 is the top carry
//   carry_o    out  carry registers; bit i feeds segment i, bit 0 is always 0
//   cout_o     out  carry-out of the top segment
// -----------------------------------------------------------------------------
module shadd_seg_datapath
    import shadd_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic           load_i,
    input  logic           adv_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   sum_o,
    output logic [W/N-1:0] seg_cout_o,
    output logic [W/N-1:0] carry_o,
    output logic           cout_o
);

    localparam int S = seg_count(W, N);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [S-1:0] carry_q;
    logic [S-1:0] carry_d;

    // Operands are pure data: captured only on load, no reset needed.
    always_ff @(posedge clk) begin
        if (load_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    always_comb begin
        carry_d = '0;
        for (int i = 1; i < S; i++) begin
            carry_d[i] = seg_cout_o[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            carry_q <= '0;
        end else if (load_i) begin
            carry_q <= '0;
        end else if (adv_i) begin
            carry_q <= carry_d;
        end
    end

    for (genvar g = 0; g < S; g++) begin : g_seg
        logic [N:0] seg_sum;
        logic       cin;
        if (g == 0) begin : g_lsb
            assign cin = 1'b0;
        end else begin : g_upper
            assign cin = carry_q[g];
        end
        assign seg_sum = {1'b0, a_q[g*N +: N]} + {1'b0, b_q[g*N +: N]} + {{N{1'b0}}, cin};
        assign sum_o[g*N +: N] = seg_sum[N-1:0];
        assign seg_cout_o[g]   = seg_sum[N];
    end

    assign carry_o = carry_q;
    assign cout_o  = seg_cout_o[S-1];

endmodule

// File: rtl/shadd_sched.sv
// -----------------------------------------------------------------------------
// shadd_sched
//
// Shares one segmented, carry-registered adder (shadd_seg_datapath) among R
// requesters. A round-robin arbiter grants one request at a time, the add is
// given S = W/N cycles to settle, and the sum is returned tagged with the
// requester index. Throughput is one add per S+2 cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_       in   asynchronous active-low reset
//   req_valid  in   [R]    per-requester request
//   req_ready  out  [R]    one-hot grant (only in IDLE)
//   req_a      in   [R*W]  operand A, requester i at [i*W +: W]
//   req_b      in   [R*W]  operand B, same packing
//   rsp_valid  out         result available
//   rsp_ready  in          consumer accepts result
//   rsp_id     out  [IDW]  requester that issued the result
//   rsp_sum    out  [W]    (A+B) mod 2^W
//   rsp_cout   out         carry out of the top segment
//   busy       out         high from acceptance until the response is taken
//
// Build option: define SHADD_EARLY_DONE_EN to finish an add as soon as every
// carry register already matches the carry-out feeding it (never later than
// the fixed S-cycle path, never earlier than 2 cycles, identical results).
// -----------------------------------------------------------------------------
module shadd_sched
    import shadd_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4,
    parameter int R = 2
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [R-1:0]           req_valid,
    output logic [R-1:0]           req_ready,
    input  logic [R*W-1:0]         req_a,
    input  logic [R*W-1:0]         req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [id_width(R)-1:0] rsp_id,
    output logic [W-1:0]           rsp_sum,
    output logic                   rsp_cout,
    output logic                   busy
);

    localparam int S    = seg_count(W, N);
    localparam int IDW  = id_width(R);
    localparam int CNTW = (S <= 1) ? 1 : $clog2(S);

    if (!params_ok(W, N)) begin : g_param_err
        $error("shadd_sched: W must be a non-zero multiple of N");
    end

    state_e          state_q;
    state_e          state_d;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  rr_d;
    logic [IDW-1:0]  id_q;
    logic [CNTW-1:0] cnt_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_sum_q;
    logic            rsp_cout_q;

    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            load;
    logic            adv;
    logic            finish;
    logic            early_ok;

    logic [W-1:0]    dp_sum;
    logic [S-1:0]    dp_seg_cout;
    logic [S-1:0]    dp_carry;
    logic            dp_cout;

    // Round-robin pick: scan from the farthest offset down to the pointer so
    // the nearest valid requester at or after rr_q is the last one written.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = R - 1; off >= 0; off--) begin
            idx = (int'(rr_q) + off) % R;
            if (req_valid[idx]) begin
                grant_idx = IDW'(idx);
                grant_any = 1'b1;
            end
        end
    end

    assign rr_d = IDW'((int'(grant_idx) + 1) % R);

    shadd_seg_datapath #(
        .W (W),
        .N (N)
    ) u_dp (
        .clk        (clk),
        .rst_       (rst_),
        .load_i     (load),
        .adv_i      (adv),
        .a_i        (req_a[grant_idx*W +: W]),
        .b_i        (req_b[grant_idx*W +: W]),
        .sum_o      (dp_sum),
        .seg_cout_o (dp_seg_cout),
        .carry_o    (dp_carry),
        .cout_o     (dp_cout)
    );

`ifdef SHADD_EARLY_DONE_EN
    // Once every carry register equals the carry-out it is fed from, the
    // carries are a fixed point of the chain and the sum can no longer move.
    logic settled;
    always_comb begin
        settled = 1'b1;
        for (int i = 1; i < S; i++) begin
            if (dp_seg_cout[i-1] != dp_carry[i]) begin
                settled = 1'b0;
            end
        end
    end
    assign early_ok = settled && (cnt_q != '0);
`else
    assign early_ok = 1'b0;
`endif

    // Per-segment carry bits are only read by the early-completion comparator.
    logic unused_dp;
    assign unused_dp = ^{dp_seg_cout, dp_carry};

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load)      state_d = ST_RUN;
            ST_RUN:  if (finish)    state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output / control logic. The grant is also held off while rst_ is low so
    // req_ready reads as zero throughout reset.
    always_comb begin
        req_ready = '0;
        load      = 1'b0;
        adv       = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any && rst_) begin
                    req_ready[grant_idx] = 1'b1;
                    load                 = 1'b1;
                end
            end
            ST_RUN: begin
                adv    = 1'b1;
                finish = (cnt_q == CNTW'(S - 1)) || early_ok;
            end
            default: ;
        endcase
    end

    // Pointer, settle counter and response registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rr_q        <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            if (load) begin
                rr_q  <= rr_d;
                id_q  <= grant_idx;
                cnt_q <= '0;
            end else if (adv) begin
                cnt_q <= cnt_q + CNTW'(1);
            end

            if (finish) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_sum_q   <= dp_sum;
                rsp_cout_q  <= dp_cout;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shadd_sched.sv
// -----------------------------------------------------------------------------
// tb_shadd_sched
//
// Directed bench for shadd_sched with W=16, N=4 (S=4), R=2. A table of
// operand vectors with hand-computed sums, carries and latencies is applied
// one request at a time, followed by hand-written sequences for round-robin
// alternation, response backpressure, reset during an add and operand changes
// after acceptance. Latency expectations follow SHADD_EARLY_DONE_EN.
// -----------------------------------------------------------------------------
module tb_shadd_sched;

    localparam int W = 16;
    localparam int N = 4;
    localparam int R = 2;
    localparam int S = W / N;

`ifdef SHADD_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*W-1:0] req_a;
    logic [R*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [0:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    shadd_sched #(.W(W), .N(N), .R(R)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        int          lat_early;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int early);
        return EARLY ? early : S;
    endfunction

    // Raise one request, wait for its grant, drop it after the acceptance
    // edge (replacing operand A with a_after), then count edges to rsp_valid.
    task automatic do_req(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] a_after, output int lat, output bit ok);
        int waitc;
        ok    = 1'b1;
        lat   = 0;
        waitc = 0;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx]    = 1'b1;
        #1;
        while (!req_ready[idx] && waitc < 30) begin
            tick();
            waitc++;
        end
        if (!req_ready[idx]) begin
            ok             = 1'b0;
            req_valid[idx] = 1'b0;
            return;
        end
        tick();
        req_valid[idx]    = 1'b0;
        req_a[idx*W +: W] = a_after;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!rsp_valid) ok = 1'b0;
    endtask

    task automatic run_vec(input string name, input int idx, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] a_after,
                           input logic [15:0] esum, input logic ecout, input int elat);
        int lat;
        bit ok;
        do_req(idx, a, b, a_after, lat, ok);
        check({name, "_rsp_seen"}, 32'(ok), 32'd1);
        check({name, "_sum"}, 32'(rsp_sum), 32'(esum));
        check({name, "_cout"}, 32'(rsp_cout), 32'(ecout));
        check({name, "_id"}, 32'(rsp_id), 32'(idx));
        check({name, "_latency"}, 32'(lat), 32'(exp_lat(elat)));
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        bit ok;
        int bad;
        int ng;
        int nr;
        int gcyc[3];
        logic [R-1:0] gval[3];
        logic [0:0]   rid[2];
        logic [15:0]  rsum[2];
        logic         rcout[2];

        vecs[0] = '{0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 2};
        vecs[1] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 2};
        vecs[2] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4};
        vecs[3] = '{1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2};
        vecs[4] = '{0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 2};
        vecs[5] = '{1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 3};
        vecs[6] = '{0, 16'hABCD, 16'h1234, 16'hBE01, 1'b0, 3};
        vecs[7] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 2};
        vecs[8] = '{0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4};

        for (int i = 0; i < 3; i++) begin
            gcyc[i] = -100;
            gval[i] = 'x;
        end
        for (int i = 0; i < 2; i++) begin
            rid[i]   = 'x;
            rsum[i]  = 'x;
            rcout[i] = 'x;
        end

        // ---------------- reset state (requests pending during reset) ----
        rst_      = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_cout", 32'(rsp_cout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        req_valid = '0;
        rst_      = 1'b1;
        tick();

        // ---------------- round robin and tagging --------------------------
        req_a     = {16'h8000, 16'h0003};
        req_b     = {16'h8000, 16'h0004};
        req_valid = 2'b11;
        ng = 0;
        nr = 0;
        #1;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            if (req_ready != '0) begin
                gval[ng] = req_ready;
                gcyc[ng] = c;
                ng++;
            end
            if (rsp_valid && nr < 2) begin
                rid[nr]   = rsp_id;
                rsum[nr]  = rsp_sum;
                rcout[nr] = rsp_cout;
                nr++;
            end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 30 && busy; c++) tick();
        check("rr_grant_count", 32'(ng), 32'd3);
        check("rr_grant0", 32'(gval[0]), 32'b01);
        check("rr_grant1", 32'(gval[1]), 32'b10);
        check("rr_grant2", 32'(gval[2]), 32'b01);
        check("rr_spacing01", 32'(gcyc[1] - gcyc[0]), 32'(exp_lat(2) + 2));
        check("rr_spacing12", 32'(gcyc[2] - gcyc[1]), 32'(exp_lat(2) + 2));
        check("rr_rsp0_id", 32'(rid[0]), 32'd0);
        check("rr_rsp0_sum", 32'(rsum[0]), 32'h0007);
        check("rr_rsp0_cout", 32'(rcout[0]), 32'd0);
        check("rr_rsp1_id", 32'(rid[1]), 32'd1);
        check("rr_rsp1_sum", 32'(rsum[1]), 32'h0000);
        check("rr_rsp1_cout", 32'(rcout[1]), 32'd1);
        check("rr_drained", 32'(busy), 32'd0);
        tick();

        // ---------------- backpressure -------------------------------------
        rsp_ready = 1'b0;
        do_req(0, 16'h0005, 16'h000A, 16'h0005, lat, ok);
        check("bp_rsp_seen", 32'(ok), 32'd1);
        req_a[W +: W] = 16'h0010;
        req_b[W +: W] = 16'h0020;
        req_valid[1]  = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_sum !== 16'h000F || rsp_cout !== 1'b0 ||
                rsp_id !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) bad++;
            tick();
        end
        check("bp_hold_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_in_handshake", 32'(req_ready), 32'd0);
        tick();
        check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b10);
        tick();
        req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_second_sum", 32'(rsp_sum), 32'h0030);
        check("bp_second_id", 32'(rsp_id), 32'd1);
        tick();

        // ---------------- reset during an add ------------------------------
        req_a[0 +: W] = 16'h1234;
        req_b[0 +: W] = 16'h1111;
        req_valid[0]  = 1'b1;
        bad = 0;
        #1;
        for (int c = 0; c < 30 && !req_ready[0]; c++) tick();
        check("mr_granted", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        if (rsp_valid) bad++;
        tick();
        if (rsp_valid) bad++;
        rst_ = 1'b0;
        #1;
        check("mr_outputs_cleared", {27'd0, rsp_valid, req_ready, busy, rsp_cout}, 32'd0);
        check("mr_rsp_id", 32'(rsp_id), 32'd0);
        check("mr_rsp_sum", 32'(rsp_sum), 32'd0);
        tick();
        rst_ = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid || busy) bad++;
            tick();
        end
        check("mr_no_response", 32'(bad), 32'd0);

        // ---------------- operand change after acceptance ------------------
        run_vec("opchg", 0, 16'h0001, 16'h0001, 16'h7FFF, 16'h0002, 1'b0, 2);

        // ---------------- directed vector table ----------------------------
        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b,
                    vecs[i].a, vecs[i].sum, vecs[i].cout, vecs[i].lat_early);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadd_sched.md
Name: shadd_sched

Overview:
- Sequences and shares one segmented, carry-registered adder datapath among R requesters.
- The datapath splits a W-bit add into S=W/N N-bit segments with registered inter-segment carries, so it needs S cycles to settle.
- This block arbitrates requests round-robin, launches one add at a time, counts the settle cycles, and returns the sum tagged with the requester id.
- It sits between accumulator/counter clients and the adder, so each client can use a wide add without a long ripple path.

Parameters:
- W, 16, total operand width; must be a multiple of N.
- N, 4, segment width; S=W/N segments; N=W gives S=1 (single-cycle add).
- R, 2, number of requesters, R>=1; IDW=max(1,clog2(R)).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_  in  1  asynchronous active-low reset.
- req_valid  in  R  per-requester request.
- req_ready  out  R  one-hot grant; acceptance = req_valid[i]&req_ready[i].
- req_a  in  R*W  operand A, requester i at [i*W +: W].
- req_b  in  R*W  operand B, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that issued the result.
- rsp_sum  out  W  (A+B) mod 2^W.
- rsp_cout  out  1  carry out of the top segment.
- busy  out  1  high from acceptance until the response is taken.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, RR pointer=0, state=IDLE, segment carry regs=0.
- States:
  - IDLE: req_ready is combinationally one-hot to the first valid requester at or after the RR pointer; zero if none valid.
  - On acceptance edge k: latch operands and id, clear all carry regs, cnt=0, RR pointer=(granted+1) mod R, go to RUN.
  - RUN: req_ready=0. Each edge, carry reg i <= cout of segment i-1 (segment 0 cin is always 0), cnt++.
  - When cnt reaches S-1, on the next edge register sum/cout into rsp_*, set rsp_valid, go to DONE.
  - Latency: rsp_valid first high in cycle k+S (S=1 gives the cycle after acceptance).
  - DONE: hold rsp_* stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready, clear rsp_valid and return to IDLE.
  - No new grant in the same cycle as rsp handshake; next accept is earliest the following cycle. Throughput is 1 add per S+2 cycles.
- Requester rules: req_valid may drop without acceptance. Operands are sampled only on the acceptance edge; later changes are ignored.
- Arithmetic: 0xFFFF+0x0001 wraps to sum=0, cout=1. The carry propagates one segment per cycle, which is exactly covered by S cycles.
- Non-granted requesters see req_ready=0 and must wait.
- rst_ asserted mid-RUN/DONE: abort immediately, return to reset values, no response produced.

Optional Feature:
- SHADD_EARLY_DONE_EN defined:
  - In RUN with cnt>=1, if every segment cout equals its current carry reg (S-1 comparisons), the sum is final.
  - Register the result on that edge and go to DONE.
  - Minimum latency 2 cycles; it never exceeds S. rsp_* values are identical to the non-early path.
- Undefined: fixed S-cycle latency and no comparator logic.

Decomposition:
- Package shadd_pkg holds:
  - the IDW function (clog2);
  - state encoding IDLE/RUN/DONE;
  - the segment-count helper S=W/N;
  - the parameter check W%N==0, a sim-time error if violated.
- One sub-module, shadd_seg_datapath (W, N):
  - operand regs, S N-bit adders, S-1 carry regs with a synchronous clear;
  - outputs the combinational sum, per-segment couts and top cout.
- Arbiter, counter and response regs stay in shadd_sched.

Test Plan:
- Wrap case: W=16, N=4, R=1; A=0xFFFF, B=0x0001 → rsp_sum=0x0000, rsp_cout=1, rsp_valid exactly 4 cycles after acceptance.
- Round-robin and tagging: R=2, both valid continuously with rsp_ready=1; A0=3, B0=4, A1=0x8000, B1=0x8000.
  - Grants alternate 0,1,0; rsp_id 0 with sum 7, then rsp_id 1 with sum 0 and cout 1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_* stable and req_ready=0 for all requesters throughout; after release, the next grant comes one cycle later.
- Mid-operation reset: pulse rst_ low two cycles after acceptance of 0x1234+0x1111.
  - All outputs return to reset values and no rsp_valid ever appears for that request.
- Operand change after accept: change req_a from 0x0001 to 0x7FFF the cycle after acceptance with B=0x0001 → rsp_sum=0x0002.
- SHADD_EARLY_DONE_EN: A=0x0001, B=0x0001 → rsp_valid in cycle k+2.
  - A=0xFFFF, B=0x0001 → cycle k+4.
  - Sums match the non-early build.
